// File: rtl/npu_reshape_pkg.sv
// Shared encodings for the reshape/transpose tile engine.
// Mode and FSM state types used by the top and the row mux.
package npu_reshape_pkg;

  typedef enum logic [1:0] {
    RS_MODE_PASS      = 2'd0,
    RS_MODE_TRANSPOSE = 2'd1,
    RS_MODE_ROWREV    = 2'd2,
    RS_MODE_RSVD      = 2'd3
  } rs_mode_e;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } rs_state_e;

  function automatic rs_mode_e rs_mode_fix(
    input logic [1:0] m
  );
    rs_mode_fix = (m == RS_MODE_RSVD)
                ? RS_MODE_PASS
                : rs_mode_e'(m);
  endfunction

endpackage

// File: rtl/reshape_row_mux.sv
// Output row selection from the flattened tile buffer.
// Element (r,c) lives at bits [(r*N+c)*DATA_W +: DATA_W].
module reshape_row_mux
  import npu_reshape_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int DATA_W = 16,
  localparam int ROW_W  = $clog2(N)
) (
  input  logic [N*N*DATA_W-1:0] tile,
  input  logic [ROW_W-1:0]      row,
  input  rs_mode_e              mode,
  output logic [N*DATA_W-1:0]   data
);

  always_comb begin
    data = '0;
    for (int c = 0; c < N; c++) begin
      unique case (mode)
        RS_MODE_TRANSPOSE:
          data[c*DATA_W +: DATA_W] =
            tile[(c*N + int'(row))*DATA_W +: DATA_W];
        RS_MODE_ROWREV:
          data[c*DATA_W +: DATA_W] =
            tile[(int'(row)*N + N-1-c)*DATA_W +: DATA_W];
        default:
          data[c*DATA_W +: DATA_W] =
            tile[(int'(row)*N + c)*DATA_W +: DATA_W];
      endcase
    end
  end

endmodule

// File: rtl/reshape_tile_unit.sv
// Streaming N x N tile reshape engine: fill N rows, then
// drain N rows as pass-through, transpose or row-reverse.
module reshape_tile_unit
  import npu_reshape_pkg::*;
#(
  parameter  int N      = 8,
  parameter  int DATA_W = 16,
  localparam int ROW_W  = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic [N*DATA_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [N*DATA_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                err_mode
);

  localparam logic [ROW_W-1:0] LAST = ROW_W'(N-1);

  rs_state_e        state_q, state_d;
  logic [ROW_W-1:0] wr_row_q, wr_row_d;
  logic [ROW_W-1:0] rd_row_q, rd_row_d;
  rs_mode_e         mode_q, mode_d;
  logic             err_q, err_d;

  logic [N*N*DATA_W-1:0] tile_q;
  logic                  in_acc;
  logic                  out_acc;

  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (state_q == ST_DRAIN);
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;
  assign out_last  = out_valid & (rd_row_q == LAST);
  assign busy      = (state_q == ST_DRAIN)
                   | (wr_row_q != '0);
  assign err_mode  = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      wr_row_q <= '0;
      rd_row_q <= '0;
      mode_q   <= RS_MODE_PASS;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_row_q <= wr_row_d;
      rd_row_q <= rd_row_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_row_d = wr_row_q;
    rd_row_d = rd_row_q;
    mode_d   = mode_q;
    err_d    = err_q;
    unique case (state_q)
      ST_FILL: begin
        if (in_acc) begin
          if (wr_row_q == '0) begin
            mode_d = rs_mode_fix(mode);
            if (mode == RS_MODE_RSVD) err_d = 1'b1;
          end
          if (wr_row_q == LAST) begin
            state_d  = ST_DRAIN;
            wr_row_d = '0;
            rd_row_d = '0;
          end else begin
            wr_row_d = wr_row_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (out_acc) begin
          if (rd_row_q == LAST) begin
            state_d  = ST_FILL;
            rd_row_d = '0;
          end else begin
            rd_row_d = rd_row_q + 1'b1;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  // Tile storage carries no reset; rows are rewritten each fill.
  always_ff @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      if (!rst && in_acc && wr_row_q == ROW_W'(r))
        tile_q[r*N*DATA_W +: N*DATA_W] <= in_data;
    end
  end

  reshape_row_mux #(
    .N      (N),
    .DATA_W (DATA_W)
  ) u_mux (
    .tile (tile_q),
    .row  (rd_row_q),
    .mode (mode_q),
    .data (out_data)
  );

endmodule

// File: tb/tb_reshape_tile_unit.sv
// Randomised and directed bench for reshape_tile_unit (N=4)
// against a queue-based tile model.
module tb_reshape_tile_unit;

  localparam int N  = 4;
  localparam int DW = 16;

  logic          clk = 0;
  logic          rst;
  logic [1:0]    mode;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_ready;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          err_mode;

  reshape_tile_unit #(.N(N), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .err_mode  (err_mode)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t",
                  tag, got, exp, $time);
  endtask

  // Model: rows collected during fill, output rows queued on completion.
  logic [15:0] rows [N][N];
  int          fill_cnt;
  int          tmode;
  bit          err_m;
  logic [63:0] exp_q [$];

  function automatic logic [63:0] pat(input int r);
    logic [63:0] d;
    for (int c = 0; c < N; c++) d[c*16 +: 16] = 16'(16*r + c);
    return d;
  endfunction

  task automatic model_reset();
    fill_cnt = 0;
    tmode    = 0;
    err_m    = 0;
    exp_q.delete();
  endtask

  task automatic model_finish_tile();
    logic [63:0] o;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        case (tmode)
          1:       o[c*16 +: 16] = rows[c][r];
          2:       o[c*16 +: 16] = rows[r][N-1-c];
          default: o[c*16 +: 16] = rows[r][c];
        endcase
      end
      exp_q.push_back(o);
    end
  endtask

  task automatic model_edge(input logic v, input logic [63:0] d,
                            input logic [1:0] m, input logic rdy,
                            input logic rs);
    if (rs) begin
      model_reset();
    end else if (exp_q.size() == 0) begin
      if (v) begin
        for (int c = 0; c < N; c++) rows[fill_cnt][c] = d[c*16 +: 16];
        if (fill_cnt == 0) begin
          tmode = (m == 2'd3) ? 0 : int'(m);
          if (m == 2'd3) err_m = 1;
        end
        fill_cnt++;
        if (fill_cnt == N) begin
          fill_cnt = 0;
          model_finish_tile();
        end
      end
    end else if (rdy) begin
      void'(exp_q.pop_front());
    end
  endtask

  task automatic compare_all();
    bit dr;
    dr = (exp_q.size() != 0);
    check("in_ready",  64'(in_ready),  64'(!dr));
    check("out_valid", 64'(out_valid), 64'(dr));
    check("busy",      64'(busy),      64'(dr || fill_cnt != 0));
    check("err_mode",  64'(err_mode),  64'(err_m));
    if (dr) begin
      check("out_data", out_data, exp_q[0]);
      check("out_last", 64'(out_last), 64'(exp_q.size() == 1));
    end
  endtask

  // Called at negedge: drive, clock, update model, compare.
  task automatic step(input logic v, input logic [63:0] d,
                      input logic [1:0] m, input logic rdy,
                      input logic rs);
    rst       = rs;
    in_valid  = v;
    in_data   = d;
    mode      = m;
    out_ready = rdy;
    @(posedge clk);
    model_edge(v, d, m, rdy, rs);
    @(negedge clk);
    compare_all();
  endtask

  task automatic fill_tile(input logic [1:0] m0, input logic [1:0] m1);
    for (int r = 0; r < N; r++)
      step(1'b1, pat(r), (r == 0) ? m0 : m1, 1'b1, 1'b0);
  endtask

  task automatic drain(input int stall_beat, input int stall_len);
    int beat = 0;
    int hold = 0;
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) begin
      if (beat == stall_beat && hold < stall_len) begin
        hold++;
        step(1'b0, '0, 2'd0, 1'b0, 1'b0);
      end else begin
        beat++;
        step(1'b0, '0, 2'd0, 1'b1, 1'b0);
      end
    end
    check("drain_done", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    step(1'b0, '0, 2'd0, 1'b1, 1'b1);
    step(1'b0, '0, 2'd0, 1'b1, 1'b1);

    // PASS with fixed reference rows
    fill_tile(2'd0, 2'd0);
    check("pass_row0", out_data, 64'h0003_0002_0001_0000);
    drain(-1, 0);

    fill_tile(2'd1, 2'd1);
    check("tr_row0", out_data, 64'h0030_0020_0010_0000);
    drain(-1, 0);

    fill_tile(2'd2, 2'd2);
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    check("rrev_row1", out_data, 64'h0010_0011_0012_0013);
    drain(-1, 0);

    // Backpressure on second beat of a transpose tile
    fill_tile(2'd1, 2'd3);
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    check("bp_row1", out_data, 64'h0031_0021_0011_0001);
    drain(0, 5);

    // Reserved mode, then mode change mid-tile
    fill_tile(2'd3, 2'd1);
    check("rsvd_pass", out_data, 64'h0003_0002_0001_0000);
    check("err_set", 64'(err_mode), 64'd1);
    drain(-1, 0);
    fill_tile(2'd0, 2'd0);
    drain(-1, 0);
    check("err_sticky", 64'(err_mode), 64'd1);

    // Reset mid-drain
    fill_tile(2'd1, 2'd1);
    step(1'b0, '0, 2'd0, 1'b1, 1'b0);
    step(1'b0, '0, 2'd0, 1'b1, 1'b1);
    check("rst_ovalid", 64'(out_valid), 64'd0);
    check("rst_err",    64'(err_mode),  64'd0);
    fill_tile(2'd0, 2'd0);
    drain(-1, 0);

    // Random traffic
    for (int k = 0; k < 1500; k++) begin
      step(($urandom_range(0, 9) < 7),
           {$urandom, $urandom},
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
